// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS front end: instruction width, the J/JAL
// opcodes recognised by fetch predecode, and the fetch FSM state encoding.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_e;

    // True for the two absolute-jump opcodes whose target is encoded in the word.
    function automatic logic is_jtype(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/fetch_predecode.sv
// -----------------------------------------------------------------------------
// fetch_predecode
// Combinational J/JAL detection on the word returned by instruction memory,
// with the absolute jump target formed from the fetching PC's upper nibble.
//
// Ports:
//   pc_plus4    in  32  address of the word being fetched, plus 4
//   rdata       in  32  instruction word from memory
//   is_jump     out 1   word is J or JAL
//   jump_target out 32  {pc_plus4[31:28], rdata[25:0], 2'b00}
// -----------------------------------------------------------------------------
module fetch_predecode
    import mips_pkg::*;
(
    input  logic [31:0]        pc_plus4,
    input  logic [INSTR_W-1:0] rdata,
    output logic               is_jump,
    output logic [31:0]        jump_target
);

    assign is_jump     = is_jtype(rdata[31:26]);
    assign jump_target = {pc_plus4[31:28], rdata[25:0], 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, requests words from instruction memory
// (req/ready), holds each fetched word for decode (valid/ready) and accepts
// PC redirects from branch/jump resolution. A redirect overrides everything.
//
// Optional feature: define FETCH_PREDECODE_EN to follow J/JAL targets directly
// at capture time instead of waiting for an external redirect.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/imem_addr         request and word-aligned byte address to memory
//   imem_ready/imem_rdata      memory accept and same-cycle instruction word
//   instr_valid/instr_ready    handshake to decode
//   instr, instr_pc, pc_plus4  held instruction, its address, address + 4
//   opcode, funct              instr[31:26], instr[5:0] to the control unit
//   redirect_valid/redirect_pc taken branch/jump and its target
//   stall_cnt                  saturating count of FETCH cycles without ready
// -----------------------------------------------------------------------------
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    output logic [31:0]        pc_plus4,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [CNT_W-1:0]   stall_cnt
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [31:0]        pc_inc;
    logic [31:0]        pc_after_capture;

    // Redirect targets are word addresses; the byte-offset bits are dropped.
    logic               unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign pc_inc = pc_q + 32'd4;   // wraps modulo 2^32

`ifdef FETCH_PREDECODE_EN
    logic        pd_is_jump;
    logic [31:0] pd_target;

    fetch_predecode u_predecode (
        .pc_plus4    (pc_inc),
        .rdata       (imem_rdata),
        .is_jump     (pd_is_jump),
        .jump_target (pd_target)
    );

    assign pc_after_capture = pd_is_jump ? pd_target : pc_inc;
`else
    assign pc_after_capture = pc_inc;
`endif

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so
        // no path through the branches below can leave one unassigned (latch).
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        stall_cnt_d   = stall_cnt_q;

        // A waiting request counts as a stall even if a redirect also arrives.
        if ((state_q == S_FETCH) && !imem_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (redirect_valid) begin
            // Any word returned this cycle is dropped; a pending consume in
            // HOLD simply completes because valid is cleared either way.
            pc_d          = {redirect_pc[31:2], 2'b00};
            instr_valid_d = 1'b0;
            state_d       = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_after_capture;
                        state_d       = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    // Request depends only on state; gating with rst_n drops it the moment
    // reset asserts and raises it in the first cycle after release.
    assign imem_req    = (state_q == S_FETCH) && rst_n;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = instr_pc_q + 32'd4;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Table-driven check of fetch_unit: one vector per clock cycle, inputs applied
// on the falling edge and outputs compared 1 ns later. Hand-written sequences
// cover stall-counter saturation (narrow second instance) and async reset.
// Expected J/JAL behaviour follows FETCH_PREDECODE_EN if it is defined.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef FETCH_PREDECODE_EN
    localparam logic [31:0] JUMP_NEXT = 32'h0040_0010;
`else
    localparam logic [31:0] JUMP_NEXT = 32'h0000_1004;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [15:0] stall_cnt;

    // Narrow-counter instance, memory never ready: counter must stick at 7.
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_ipc, s_pp4;
    logic [5:0]  s_op, s_fn;
    logic [2:0]  s_stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus4       (pc_plus4),
        .opcode         (opcode),
        .funct          (funct),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_cnt      (stall_cnt)
    );

    fetch_unit #(.RESET_PC(RST_PC), .CNT_W(3)) dut_small (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (s_req),
        .imem_addr      (s_addr),
        .imem_ready     (1'b0),
        .imem_rdata     (32'h0),
        .instr_valid    (s_valid),
        .instr_ready    (1'b0),
        .instr          (s_instr),
        .instr_pc       (s_ipc),
        .pc_plus4       (s_pp4),
        .opcode         (s_op),
        .funct          (s_fn),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .stall_cnt      (s_stall)
    );

    typedef struct {
        logic        mem_rdy;
        logic [31:0] rdata;
        logic        dec_rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
        int          e_stall;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        // mem_rdy rdata dec_rdy redir rpc | e_req e_addr e_valid e_ipc e_instr e_stall
        vecs[0]  = '{1, 32'h2001_0001, 1, 0, 0, 1, 32'h0040_0000, 0, 32'h0,         32'h0,         0};
        vecs[1]  = '{1, 32'h0,         1, 0, 0, 0, 32'h0,         1, 32'h0040_0000, 32'h2001_0001, 0};
        vecs[2]  = '{1, 32'h0000_0020, 1, 0, 0, 1, 32'h0040_0004, 0, 32'h0040_0000, 32'h2001_0001, 0};
        vecs[3]  = '{1, 32'h0,         1, 0, 0, 0, 32'h0,         1, 32'h0040_0004, 32'h0000_0020, 0};
        vecs[4]  = '{0, 32'h0,         1, 0, 0, 1, 32'h0040_0008, 0, 32'h0040_0004, 32'h0000_0020, 0};
        vecs[5]  = '{0, 32'h0,         1, 0, 0, 1, 32'h0040_0008, 0, 32'h0040_0004, 32'h0000_0020, 1};
        vecs[6]  = '{0, 32'h0,         1, 0, 0, 1, 32'h0040_0008, 0, 32'h0040_0004, 32'h0000_0020, 2};
        vecs[7]  = '{0, 32'h0,         1, 0, 0, 1, 32'h0040_0008, 0, 32'h0040_0004, 32'h0000_0020, 3};
        vecs[8]  = '{0, 32'h0,         1, 0, 0, 1, 32'h0040_0008, 0, 32'h0040_0004, 32'h0000_0020, 4};
        vecs[9]  = '{1, 32'h8C02_0004, 0, 0, 0, 1, 32'h0040_0008, 0, 32'h0040_0004, 32'h0000_0020, 5};
        vecs[10] = '{0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'h0040_0008, 32'h8C02_0004, 5};
        vecs[11] = '{0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'h0040_0008, 32'h8C02_0004, 5};
        vecs[12] = '{0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'h0040_0008, 32'h8C02_0004, 5};
        vecs[13] = '{0, 32'h0,         1, 0, 0, 0, 32'h0,         1, 32'h0040_0008, 32'h8C02_0004, 5};
        // Redirect to 0x1003 collides with imem_ready: word dropped.
        vecs[14] = '{1, 32'hDEAD_BEEF, 0, 1, 32'h0000_1003, 1, 32'h0040_000C, 0, 32'h0040_0008, 32'h8C02_0004, 5};
        vecs[15] = '{0, 32'h0,         0, 0, 0, 1, 32'h0000_1000, 0, 32'h0040_0008, 32'h8C02_0004, 5};
        // J 0x0100004 fetched at 0x1000.
        vecs[16] = '{1, 32'h0810_0004, 0, 0, 0, 1, 32'h0000_1000, 0, 32'h0040_0008, 32'h8C02_0004, 6};
        vecs[17] = '{0, 32'h0,         1, 0, 0, 0, 32'h0,         1, 32'h0000_1000, 32'h0810_0004, 6};
        vecs[18] = '{0, 32'h0,         1, 0, 0, 1, JUMP_NEXT,     0, 32'h0000_1000, 32'h0810_0004, 6};
        vecs[19] = '{1, 32'h0,         1, 0, 0, 1, JUMP_NEXT,     0, 32'h0000_1000, 32'h0810_0004, 7};
        // Redirect coinciding with a consume in HOLD.
        vecs[20] = '{0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, JUMP_NEXT,   32'h0,         7};
        vecs[21] = '{1, 32'h03E0_0008, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, JUMP_NEXT,     32'h0,         7};
        vecs[22] = '{0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h03E0_0008, 7};
        vecs[23] = '{0, 32'h0,         1, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h03E0_0008, 7};
        // PC wrapped from 0xFFFFFFFC to 0.
        vecs[24] = '{0, 32'h0,         0, 0, 0, 1, 32'h0000_0000, 0, 32'hFFFF_FFFC, 32'h03E0_0008, 7};
        // External redirect beats a J capture in the same cycle.
        vecs[25] = '{1, 32'h0810_0004, 0, 1, 32'h0000_2000, 1, 32'h0000_0000, 0, 32'hFFFF_FFFC, 32'h03E0_0008, 8};
        vecs[26] = '{0, 32'h0,         0, 0, 0, 1, 32'h0000_2000, 0, 32'hFFFF_FFFC, 32'h03E0_0008, 8};

        // ---- reset values ----
        @(negedge clk);
        @(negedge clk);
        check("rst_req",      {31'h0, imem_req},    32'h0);
        check("rst_valid",    {31'h0, instr_valid}, 32'h0);
        check("rst_instr",    instr,                32'h0);
        check("rst_instr_pc", instr_pc,             32'h0);
        check("rst_pc_plus4", pc_plus4,             32'h4);
        check("rst_stall",    {16'h0, stall_cnt},   32'h0);
        check("rst_addr",     imem_addr,            RST_PC);
        rst_n = 1'b1;

        // ---- table ----
        for (int i = 0; i < NV; i++) begin
            imem_ready     = vecs[i].mem_rdy;
            imem_rdata     = vecs[i].rdata;
            instr_ready    = vecs[i].dec_rdy;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            #1;
            check($sformatf("v%0d_req", i),   {31'h0, imem_req},    {31'h0, vecs[i].e_req});
            if (vecs[i].e_req)
                check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d_ipc", i),   instr_pc,             vecs[i].e_ipc);
            check($sformatf("v%0d_pp4", i),   pc_plus4,             vecs[i].e_ipc + 32'd4);
            check($sformatf("v%0d_instr", i), instr,                vecs[i].e_instr);
            check($sformatf("v%0d_opcode", i), {26'h0, opcode},     {26'h0, vecs[i].e_instr[31:26]});
            check($sformatf("v%0d_funct", i),  {26'h0, funct},      {26'h0, vecs[i].e_instr[5:0]});
            check($sformatf("v%0d_stall", i), {16'h0, stall_cnt},   32'(vecs[i].e_stall));
            if (i == 5)
                check("small_stall_5", {29'h0, s_stall}, 32'd5);
            @(negedge clk);
        end

        // ---- narrow counter saturated ----
        check("small_stall_sat", {29'h0, s_stall}, 32'd7);
        check("small_addr_hold", s_addr, RST_PC);

        // ---- async reset with a stall pending ----
        imem_ready     = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("pre_rst_stall", {16'h0, stall_cnt}, 32'd9);
        check("pre_rst_req",   {31'h0, imem_req},  32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_req",   {31'h0, imem_req},    32'h0);
        check("async_valid", {31'h0, instr_valid}, 32'h0);
        check("async_stall", {16'h0, stall_cnt},   32'h0);
        check("async_small", {29'h0, s_stall},     32'h0);
        check("async_addr",  imem_addr,            RST_PC);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_req",  {31'h0, imem_req}, 32'h1);
        check("rel_addr", imem_addr,         RST_PC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle MIPS datapath, directly upstream of the control unit and register file. It owns the program counter and issues word requests to instruction memory over a req/ready handshake. It presents each fetched instruction to decode over a valid/ready handshake, with `opcode`/`funct` slices wired straight into the control unit. It also accepts PC redirects from branch/jump resolution.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0).
- `CNT_W`, default 16, width of the stall counter.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the request, always word aligned.
- `imem_ready`  in  1  memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  `instr` holds an instruction for decode.
- `instr_ready`  in  1  decode consumes `instr` this cycle.
- `instr`  out  32  fetched instruction.
- `instr_pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `instr_pc + 4`, used for branch/jump target calculation.
- `opcode`  out  6  `instr[31:26]`, feeds control unit Opcode.
- `funct`  out  6  `instr[5:0]`, feeds control unit Funct.
- `redirect_valid`  in  1  taken branch/jump; load `redirect_pc`.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored and treated as 0.
- `stall_cnt`  out  CNT_W  saturating count of cycles spent in FETCH with `imem_ready`=0.

## Operation
- Two states: FETCH and HOLD. Reset state is FETCH.
- FETCH behaviour:
  - Drive `imem_req`=1 and `imem_addr`=pc. Address stays stable until `imem_ready`.
  - On `imem_ready`: capture `imem_rdata` into `instr`, set `instr_pc`=pc and `instr_valid`=1, set pc=pc+4, go to HOLD.
- HOLD behaviour:
  - Drive `imem_req`=0.
  - `instr`, `instr_pc` and `instr_valid` stay stable while `instr_ready`=0.
  - On `instr_ready`: clear `instr_valid`, go to FETCH.
- Redirect has priority over every other event in either state:
  - pc={redirect_pc[31:2],2'b00}, `instr_valid`=0, next state FETCH.
  - In FETCH with `imem_ready` in the same cycle, the returned word is discarded.
  - In HOLD with `instr_ready` in the same cycle, the consume completes and nothing else changes.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- `stall_cnt`:
  - Increments each FETCH cycle with `imem_req`=1 and `imem_ready`=0.
  - Saturates at all-ones.
  - Cleared only by reset.
- Reset values: pc=`RESET_PC`, `imem_req`=0 during reset, `instr`=0, `instr_pc`=0, `instr_valid`=0, `stall_cnt`=0. `pc_plus4`, `opcode` and `funct` follow from these values.
- Reset asserted mid-operation aborts any outstanding request immediately, with no further handshake.

## Timing
- First `imem_req` in the first cycle after `rst_n` deasserts.
- Latency: `instr_valid` rises one edge after the `imem_req`&&`imem_ready` cycle.
- Peak throughput: one instruction per 2 cycles with zero-wait memory and `instr_ready` held high.
- Redirect takes effect at the next edge. The new address appears on `imem_addr` in the following cycle.
- No combinational path from `instr_ready` or `redirect_valid` to `imem_req`. `imem_req` is a function of state only.

## Configuration
- `FETCH_PREDECODE_EN` defined:
  - On capture of J (6'b000010) or JAL (6'b000011), next pc={pc_plus4[31:28], imem_rdata[25:0], 2'b00} instead of pc+4.
  - The instruction is still delivered to decode.
  - An external redirect in the same cycle still wins.
- Not defined: next pc after every capture is pc+4. All jumps rely on `redirect_valid`.

## Structure
- Shared package `mips_pkg`: `OP_J`, `OP_JAL`, `INSTR_W`=32, and the FETCH/HOLD state encoding.
- One sub-module, `fetch_predecode`: combinational J/JAL detect and target generation. It is instantiated only under `FETCH_PREDECODE_EN`.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000, `imem_ready`=1, `instr_ready`=1 -> `imem_addr` sequence 0x400000, 0x400004, 0x400008; `instr_valid` toggles each cycle; `instr_pc` matches.
- `imem_ready` low for 5 cycles -> `imem_addr` stable, `stall_cnt`=5, `instr_valid`=0 throughout.
- `instr_ready` low for 3 cycles in HOLD -> `instr` and `instr_pc` unchanged, `imem_req`=0; fetch resumes the cycle after `instr_ready`.
- `redirect_valid` with `redirect_pc`=0x1003 in the same cycle as `imem_ready` -> word dropped, next `imem_addr`=0x1000.
- With `FETCH_PREDECODE_EN`, fetch 32'h0810_0004 at 0x400000 -> next `imem_addr`=0x0040_0010. Without the macro -> next `imem_addr`=0x0040_0004.
- Assert `rst_n` low while in FETCH with a stall pending -> `imem_req`=0, `instr_valid`=0, `stall_cnt`=0 asynchronously.
